sysid_checker: RTL and testbench
================================

// Module: sysid_checker
// PURPOSE
//  Avalon-MM read master placed directly downstream of the sysid control slave.
//  Reads the system ID word (address 0) and then the timestamp word (address 1).
//  Compares both against the values the software image was built for.
//  Drives registered pass/fail status to boot-hold logic and a status LED, so a
//  mismatched FPGA image/software pair is caught before the CPU leaves reset.
// PARAMETERS
//  EXPECTED_ID        682084843   expected word at sysid address 0
//  EXPECTED_TS        1200531042  expected word at sysid address 1
//  READ_LATENCY       0           cycles from read accept to valid m_readdata (0..3)
//  TIMEOUT_CYCLES     255         max cycles m_waitrequest may hold one read (1..255)
//  AUTO_START         1           1: run one check automatically after reset release
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   request a check; sampled only in IDLE
//  m_address      out  1   sysid word select (0 = ID, 1 = timestamp)
//  m_read         out  1   Avalon read strobe
//  m_readdata     in   32  read data from sysid slave
//  m_waitrequest  in   1   Avalon wait request (tie 0 if fabric has none)
//  busy           out  1   high from start accept until done
//  done           out  1   one-cycle pulse when results become valid
//  id_ok          out  1   ID word matched EXPECTED_ID
//  ts_ok          out  1   timestamp word matched EXPECTED_TS
//  pass           out  1   id_ok & ts_ok & ~timeout
//  timeout        out  1   a read exceeded TIMEOUT_CYCLES
//  read_id        out  32  captured ID word
//  read_ts        out  32  captured timestamp word
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high.
//  - All outputs reset to 0. The FSM enters IDLE.
//  - Reset asserted mid-read drops m_read immediately and discards partial results.
//  States: IDLE -> RD_ID -> LAT_ID -> RD_TS -> LAT_TS -> CHECK -> IDLE.
//  - LAT_* states are skipped when READ_LATENCY=0.
//  IDLE
//  - Go on start=1, or on the first clock after reset release when AUTO_START=1.
//  - On go: clear id_ok/ts_ok/pass/timeout/read_id/read_ts and set busy.
//  - start while busy is ignored; it is not queued.
//  RD_ID / RD_TS
//  - m_read=1; m_address=0 in RD_ID, 1 in RD_TS.
//  - Address and read are held stable while m_waitrequest=1.
//  - Accept = m_read & ~m_waitrequest.
//  - READ_LATENCY=0: capture m_readdata on the accept cycle.
//  - READ_LATENCY>0: deassert m_read after accept, wait READ_LATENCY cycles in
//    LAT_*, then capture.
//  Timeout
//  - A wait counter resets to 0 at the entry of each RD_* state.
//  - The counter increments on each cycle with m_waitrequest=1.
//  - When the count reaches TIMEOUT_CYCLES: set timeout=1, drop m_read, and go to
//    CHECK. Any uncaptured word reads as 0 and its *_ok flag is 0.
//  CHECK (one cycle)
//  - id_ok/ts_ok are computed as exact 32-bit equality.
//  - pass = id_ok & ts_ok & ~timeout.
//  - All status flags register on exit from CHECK.
//  - done pulses high for exactly that one cycle; busy falls in the same cycle.
//  Latency: with READ_LATENCY=0 and no wait states, start sampled at edge k gives:
//  - m_read/address 0 in cycle k+1
//  - m_read/address 1 in cycle k+2
//  - CHECK in cycle k+3
//  - done with flags valid in cycle k+4
//  Each extra wait or latency cycle adds 1.
//  Flags and read_* hold until the next accepted start or reset.
//  Never more than one outstanding read. m_read=0 outside RD_* states.
// TESTING
//  1) Slave returns 682084843 / 1200531042, no wait, start pulse
//     -> done at cycle +4; pass=1, id_ok=1, ts_ok=1.
//  2) Address 1 returns 0x00000000
//     -> id_ok=1, ts_ok=0, pass=0, read_ts=0, timeout=0.
//  3) m_waitrequest held 3 cycles on each read
//     -> address held stable throughout; done at cycle +10; pass=1.
//  4) m_waitrequest stuck high, TIMEOUT_CYCLES=255
//     -> m_read drops after 255 wait cycles; timeout=1, pass=0, done pulses once.
//  5) READ_LATENCY=2, with start re-pulsed while busy
//     -> data captured 2 cycles after each accept; second start ignored; one done.
//  6) reset asserted during RD_TS, then AUTO_START=1 on release
//     -> m_read=0 at once, all flags 0; new check runs from address 0 and passes.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the sysid ID and timestamp words
// and reports whether they match the values this software image was built against.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd682084843,
   parameter logic [31:0] EXPECTED_TS    = 32'd1200531042,
   parameter int          READ_LATENCY   = 0,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] read_id,
   output logic [31:0] read_ts
);

   typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] LAT_LAST  = 2'(READ_LATENCY - 1);
   localparam bit         NO_LAT    = (READ_LATENCY == 0);

   state_t     state;
   state_t     nextState;
   logic       autoPending;
   logic [7:0] waitCount;
   logic [1:0] latCount;
   logic       gotId;
   logic       gotTs;
   logic       timedOut;
   logic       go;
   logic       accept;
   logic       waitExpire;
   logic       latDone;
   logic       captureId;
   logic       captureTs;

   // State register; an asserted reset drops m_read at once because it is decoded from state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state and bus strobes; a timeout on either read jumps straight to CHECK.
   always_comb begin
      nextState  = state;
      m_read     = (state == RD_ID) || (state == RD_TS);
      m_address  = (state == RD_TS);
      go         = (state == IDLE) && (start || autoPending);
      accept     = m_read && !m_waitrequest;
      waitExpire = m_read && m_waitrequest && (waitCount == WAIT_LAST);
      latDone    = (latCount == LAT_LAST);
      captureId  = NO_LAT ? (state == RD_ID && accept) : (state == LAT_ID && latDone);
      captureTs  = NO_LAT ? (state == RD_TS && accept) : (state == LAT_TS && latDone);
      case (state)
         IDLE:    if (go) nextState = RD_ID;
         RD_ID:   if (waitExpire) nextState = CHECK;
                  else if (accept) nextState = NO_LAT ? RD_TS : LAT_ID;
         LAT_ID:  if (latDone) nextState = RD_TS;
         RD_TS:   if (waitExpire) nextState = CHECK;
                  else if (accept) nextState = NO_LAT ? CHECK : LAT_TS;
         LAT_TS:  if (latDone) nextState = CHECK;
         CHECK:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Capture, wait/latency counting and the status flags, which only change leaving CHECK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         autoPending <= AUTO_START;
         waitCount   <= '0;
         latCount    <= '0;
         gotId       <= 1'b0;
         gotTs       <= 1'b0;
         timedOut    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         read_id     <= '0;
         read_ts     <= '0;
      end else begin
         done <= 1'b0;
         if (!m_read || accept) waitCount <= '0;
         else if (m_waitrequest) waitCount <= waitCount + 8'd1;
         if ((state == LAT_ID || state == LAT_TS) && !latDone) latCount <= latCount + 2'd1;
         else latCount <= '0;
         if (go) begin
            autoPending <= 1'b0;
            busy        <= 1'b1;
            gotId       <= 1'b0;
            gotTs       <= 1'b0;
            timedOut    <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            read_id     <= '0;
            read_ts     <= '0;
         end
         if (captureId) begin
            read_id <= m_readdata;
            gotId   <= 1'b1;
         end
         if (captureTs) begin
            read_ts <= m_readdata;
            gotTs   <= 1'b1;
         end
         if (waitExpire) timedOut <= 1'b1;
         if (state == CHECK) begin
            id_ok   <= gotId && (read_id == EXPECTED_ID);
            ts_ok   <= gotTs && (read_ts == EXPECTED_TS);
            pass    <= gotId && gotTs && (read_id == EXPECTED_ID) &&
                       (read_ts == EXPECTED_TS) && !timedOut;
            timeout <= timedOut;
            done    <= 1'b1;
            busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: drives two checker instances (zero and two-cycle read latency)
// against a small sysid slave model and compares every cycle with a window-based model.
module tb_sysid_checker;

   localparam logic [31:0] EID  = 32'd682084843;
   localparam logic [31:0] ETS  = 32'd1200531042;
   localparam int          TMAX = 255;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  start = 2'b00;
   logic [1:0]  mRead, mAddr, mWait, dBusy, dDone, dIdOk, dTsOk, dPass, dTo;
   logic [31:0] rdata [2];
   logic [31:0] rid [2];
   logic [31:0] rts [2];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   logic [31:0] mem [2][2];
   int          waitn [2];
   int          wcnt [2];
   int          lat [2];
   int          pend = 0;
   logic        pendAddr = 1'b0;

   bit          active [2];
   int          kS [2], idL [2], tsF [2], tsL [2], dn [2];
   bit          tsRd [2];
   logic        expTo [2], expIdOk [2], expTsOk [2];
   logic [31:0] expRid [2], expRts [2];

   sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(0),
                   .TIMEOUT_CYCLES(TMAX), .AUTO_START(1'b1)) dutA (
      .clk(clk), .reset(reset), .start(start[0]), .m_address(mAddr[0]), .m_read(mRead[0]),
      .m_readdata(rdata[0]), .m_waitrequest(mWait[0]), .busy(dBusy[0]), .done(dDone[0]),
      .id_ok(dIdOk[0]), .ts_ok(dTsOk[0]), .pass(dPass[0]), .timeout(dTo[0]),
      .read_id(rid[0]), .read_ts(rts[0]));

   sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(2),
                   .TIMEOUT_CYCLES(TMAX), .AUTO_START(1'b0)) dutB (
      .clk(clk), .reset(reset), .start(start[1]), .m_address(mAddr[1]), .m_read(mRead[1]),
      .m_readdata(rdata[1]), .m_waitrequest(mWait[1]), .busy(dBusy[1]), .done(dDone[1]),
      .id_ok(dIdOk[1]), .ts_ok(dTsOk[1]), .pass(dPass[1]), .timeout(dTo[1]),
      .read_id(rid[1]), .read_ts(rts[1]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: programmable wait states per read; instance B returns data two cycles after accept.
   assign mWait[0] = mRead[0] && (wcnt[0] < waitn[0]);
   assign mWait[1] = mRead[1] && (wcnt[1] < waitn[1]);
   assign rdata[0] = mRead[0] ? mem[0][mAddr[0]] : 32'hDEADBEEF;
   assign rdata[1] = (pend == 1) ? mem[1][pendAddr] : 32'hDEADBEEF;

   always @(posedge clk) begin
      wcnt[0] <= (mRead[0] && mWait[0]) ? wcnt[0] + 1 : 0;
      wcnt[1] <= (mRead[1] && mWait[1]) ? wcnt[1] + 1 : 0;
      if (mRead[1] && !mWait[1]) begin
         pendAddr <= mAddr[1];
         pend     <= 2;
      end else if (pend > 0) begin
         pend <= pend - 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected bus windows and results for a check whose start is sampled at edge k.
   task automatic modelStart(input int i, input int k);
      active[i] = 1'b1;
      kS[i]     = k;
      if (waitn[i] >= TMAX) begin
         idL[i] = k + TMAX;
         tsRd[i] = 1'b0;
         tsF[i] = 0;
         tsL[i] = 0;
         dn[i] = k + TMAX + 2;
         expTo[i] = 1'b1;
         expRid[i] = '0;
         expRts[i] = '0;
      end else begin
         idL[i] = k + 1 + waitn[i];
         tsRd[i] = 1'b1;
         tsF[i] = idL[i] + 1 + lat[i];
         tsL[i] = tsF[i] + waitn[i];
         dn[i] = tsL[i] + lat[i] + 2;
         expTo[i] = 1'b0;
         expRid[i] = mem[i][0];
         expRts[i] = mem[i][1];
      end
      expIdOk[i] = !expTo[i] && (expRid[i] == EID);
      expTsOk[i] = !expTo[i] && (expRts[i] == ETS);
   endtask

   task automatic applyStimulus(input int i);
      @(posedge clk);
      #2;
      start[i] = 1'b1;
      modelStart(i, cyc + 1);
      @(posedge clk);
      #2;
      start[i] = 1'b0;
   endtask

   task automatic waitDone(input int i, output int at);
      at = -1;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (dDone[i]) begin
            at = cyc + 1;
            break;
         end
      end
      if (at < 0) checkOutput($sformatf("wait_done[%0d]", i), 32'd0, 32'd1);
   endtask

   // Per-cycle comparison of both instances against the model windows.
   always @(negedge clk) begin : compare
      int c;
      bit inId, inTs;
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            c = cyc + 1;
            inId = active[i] && c >= kS[i] + 1 && c <= idL[i];
            inTs = active[i] && tsRd[i] && c >= tsF[i] && c <= tsL[i];
            checkOutput($sformatf("m_read[%0d]", i), 32'(mRead[i]), 32'(inId || inTs));
            if (inId || inTs)
               checkOutput($sformatf("m_address[%0d]", i), 32'(mAddr[i]), 32'(inTs));
            checkOutput($sformatf("done[%0d]", i), 32'(dDone[i]), 32'(active[i] && c == dn[i]));
            checkOutput($sformatf("busy[%0d]", i), 32'(dBusy[i]),
                        32'(active[i] && c > kS[i] && c < dn[i]));
            if (active[i] && c >= dn[i]) begin
               checkOutput($sformatf("id_ok[%0d]", i), 32'(dIdOk[i]), 32'(expIdOk[i]));
               checkOutput($sformatf("ts_ok[%0d]", i), 32'(dTsOk[i]), 32'(expTsOk[i]));
               checkOutput($sformatf("pass[%0d]", i), 32'(dPass[i]),
                           32'(expIdOk[i] && expTsOk[i] && !expTo[i]));
               checkOutput($sformatf("timeout[%0d]", i), 32'(dTo[i]), 32'(expTo[i]));
               checkOutput($sformatf("read_id[%0d]", i), rid[i], expRid[i]);
               checkOutput($sformatf("read_ts[%0d]", i), rts[i], expRts[i]);
            end else if (!active[i] || c > kS[i]) begin
               checkOutput($sformatf("flags_clear[%0d]", i),
                           32'({dIdOk[i], dTsOk[i], dPass[i], dTo[i]}), 32'd0);
               if (!active[i])
                  checkOutput($sformatf("read_clear[%0d]", i), rid[i] | rts[i], 32'd0);
            end
         end
      end
   end

   initial begin : stimulus
      int at;
      int extra;
      mem[0][0] = EID;  mem[0][1] = ETS;
      mem[1][0] = EID;  mem[1][1] = ETS;
      waitn[0] = 0;     waitn[1] = 0;
      lat[0] = 0;       lat[1] = 2;
      active[0] = 1'b0; active[1] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      modelStart(0, cyc + 1);

      // Automatic check after reset release
      waitDone(0, at);
      checkOutput("auto_latency", 32'(at - kS[0]), 32'd4);
      checkOutput("auto_pass", 32'(dPass[0]), 32'd1);

      // 1) clean read, start pulse
      applyStimulus(0);
      waitDone(0, at);
      checkOutput("t1_latency", 32'(at - kS[0]), 32'd4);
      checkOutput("t1_pass", 32'({dPass[0], dIdOk[0], dTsOk[0]}), 32'b111);

      // 2) timestamp word reads zero
      mem[0][1] = 32'd0;
      applyStimulus(0);
      waitDone(0, at);
      checkOutput("t2_flags", 32'({dIdOk[0], dTsOk[0], dPass[0], dTo[0]}), 32'b1000);
      checkOutput("t2_read_ts", rts[0], 32'd0);
      mem[0][1] = ETS;

      // 3) three wait states on each read
      waitn[0] = 3;
      applyStimulus(0);
      waitDone(0, at);
      checkOutput("t3_latency", 32'(at - kS[0]), 32'd10);
      checkOutput("t3_pass", 32'(dPass[0]), 32'd1);

      // 4) waitrequest stuck high
      waitn[0] = 1000;
      applyStimulus(0);
      waitDone(0, at);
      checkOutput("t4_latency", 32'(at - kS[0]), 32'd257);
      checkOutput("t4_flags", 32'({dTo[0], dPass[0], dIdOk[0], dTsOk[0]}), 32'b1000);
      checkOutput("t4_read_id", rid[0], 32'd0);
      waitn[0] = 0;

      // 5) two-cycle read latency, start re-pulsed while busy
      applyStimulus(1);
      repeat (2) @(posedge clk);
      #2;
      start[1] = 1'b1;
      @(posedge clk);
      #2;
      start[1] = 1'b0;
      waitDone(1, at);
      checkOutput("t5_latency", 32'(at - kS[1]), 32'd8);
      checkOutput("t5_pass", 32'(dPass[1]), 32'd1);
      checkOutput("t5_read_ts", rts[1], ETS);
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (dDone[1]) extra++;
      end
      checkOutput("t5_extra_done", 32'(extra), 32'd0);

      // 6) reset during the timestamp read, then automatic restart
      applyStimulus(0);
      for (int n = 0; n < 20 && (cyc + 1) != tsF[0]; n++) begin
         @(posedge clk);
         #2;
      end
      checkOutput("t6_in_rd_ts", 32'({mRead[0], mAddr[0]}), 32'b11);
      reset = 1'b1;
      active[0] = 1'b0;
      active[1] = 1'b0;
      #1;
      checkOutput("t6_read_drop", 32'(mRead[0]), 32'd0);
      checkOutput("t6_flags", 32'({dBusy[0], dDone[0], dIdOk[0], dTsOk[0], dPass[0], dTo[0]}), 32'd0);
      checkOutput("t6_read_id", rid[0], 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      modelStart(0, cyc + 1);
      waitDone(0, at);
      checkOutput("t6_latency", 32'(at - kS[0]), 32'd4);
      checkOutput("t6_pass", 32'(dPass[0]), 32'd1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
